// File: rtl/race_pkg.sv
// race_pkg
// Shared definitions for the race sequencing controller: state encodings,
// key bit positions, screen geometry and a saturating counter helper.
package race_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_COUNTDOWN = 2'b01,
    ST_RACE      = 2'b10,
    ST_FINISH    = 2'b11
  } race_state_e;

  // Bit positions within the one-hot key vector.
  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;

  // Screen geometry and car sprite size in pixels.
  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;
  localparam int CAR_SIZE = 64;

  // Position buses carry one bit of headroom above the screen width.
  localparam int POS_W = $clog2(SCREEN_W) + 1;

  localparam logic [15:0] TIME_MAX = 16'hFFFF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == TIME_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/box_hit.sv
// box_hit
// Combinational inclusive box test on the car's top-left corner.
// Parameters X0/X1/Y0/Y1 give the inclusive box corners.
// Ports:
//   xpos, ypos : car position (unsigned)
//   hit        : 1 when X0 <= xpos <= X1 and Y0 <= ypos <= Y1
module box_hit
  import race_pkg::*;
#(
  parameter int X0 = 0,
  parameter int X1 = 0,
  parameter int Y0 = 0,
  parameter int Y1 = 0
) (
  input  logic [POS_W-1:0] xpos,
  input  logic [POS_W-1:0] ypos,
  output logic             hit
);

  localparam logic [POS_W-1:0] X0_L = POS_W'(X0);
  localparam logic [POS_W-1:0] X1_L = POS_W'(X1);
  localparam logic [POS_W-1:0] Y0_L = POS_W'(Y0);
  localparam logic [POS_W-1:0] Y1_L = POS_W'(Y1);

  assign hit = (xpos >= X0_L) && (xpos <= X1_L) &&
               (ypos >= Y0_L) && (ypos <= Y1_L);

endmodule

// File: rtl/race_ctl.sv
// race_ctl
// Race sequencing controller: start / countdown / race / finish. Gates the
// car's keys, pulses a car reset before each race, counts laps from the
// checkpoint and finish-line boxes and times the race in frames.
// Optional feature macro: RACE_CTL_BEST_LAP_EN adds a per-lap timer and the
// best_lap output (fastest completed lap, in frames).
// Ports:
//   pclk, rst_n  : pixel clock, asynchronous active-low reset
//   frame_ended  : one-cycle pulse per video frame
//   start_btn    : start button level (synchronous to pclk)
//   key_in       : decoded one-hot keys
//   xpos, ypos   : car position
//   key_out      : gated keys to the car controller
//   car_rst      : one-cycle car reset pulse at race start
//   state        : IDLE=00 COUNTDOWN=01 RACE=10 FINISH=11
//   countdown    : digit 3..1 during COUNTDOWN, else 0
//   lap          : completed laps
//   race_time    : frames spent in RACE, saturating
//   finished     : high while in FINISH
//   best_lap     : (RACE_CTL_BEST_LAP_EN only) fastest lap in frames
module race_ctl
  import race_pkg::*;
#(
  parameter int COUNT_FRAMES = 60,
  parameter int LAPS         = 3,
  parameter int CP_X0        = 700,
  parameter int CP_X1        = 760,
  parameter int CP_Y0        = 300,
  parameter int CP_Y1        = 400,
  parameter int FL_X0        = 280,
  parameter int FL_X1        = 340,
  parameter int FL_Y0        = 200,
  parameter int FL_Y1        = 300
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             frame_ended,
  input  logic             start_btn,
  input  logic [3:0]       key_in,
  input  logic [POS_W-1:0] xpos,
  input  logic [POS_W-1:0] ypos,
  output logic [3:0]       key_out,
  output logic             car_rst,
  output logic [1:0]       state,
  output logic [1:0]       countdown,
  output logic [3:0]       lap,
  output logic [15:0]      race_time,
  output logic             finished
`ifdef RACE_CTL_BEST_LAP_EN
  ,
  output logic [15:0]      best_lap
`endif
);

  localparam int FC_W = (COUNT_FRAMES > 1) ? $clog2(COUNT_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(COUNT_FRAMES - 1);
  localparam logic [3:0]      LAPS_L  = 4'(LAPS);

  race_state_e     state_q, state_d;
  logic            start_btn_q, start_btn_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]      countdown_q, countdown_d;
  logic [3:0]      lap_q, lap_d;
  logic [15:0]     race_time_q, race_time_d;
  logic            cp_armed_q, cp_armed_d;
  logic [3:0]      key_out_q, key_out_d;
  logic            car_rst_q, car_rst_d;
  logic            finished_q, finished_d;
`ifdef RACE_CTL_BEST_LAP_EN
  logic [15:0]     lap_timer_q, lap_timer_d;
  logic [15:0]     best_lap_q, best_lap_d;
  logic [15:0]     lap_time_now;
`endif

  logic start_rise;
  logic cp_hit;
  logic fl_hit;
  logic [3:0] lap_next;

  box_hit #(
    .X0(CP_X0), .X1(CP_X1), .Y0(CP_Y0), .Y1(CP_Y1)
  ) u_cp_box (
    .xpos(xpos),
    .ypos(ypos),
    .hit (cp_hit)
  );

  box_hit #(
    .X0(FL_X0), .X1(FL_X1), .Y0(FL_Y0), .Y1(FL_Y1)
  ) u_fl_box (
    .xpos(xpos),
    .ypos(ypos),
    .hit (fl_hit)
  );

  assign start_rise = start_btn & ~start_btn_q;
  assign lap_next   = lap_q + 4'd1;

  // Next-state and datapath. A lap needs the checkpoint to be armed first;
  // when both boxes are hit in one frame the armed checkpoint is consumed by
  // the lap, so a fresh checkpoint visit is required for the next one.
  always_comb begin
    state_d     = state_q;
    start_btn_d = start_btn;
    frame_cnt_d = frame_cnt_q;
    countdown_d = countdown_q;
    lap_d       = lap_q;
    race_time_d = race_time_q;
    cp_armed_d  = cp_armed_q;
    car_rst_d   = 1'b0;
`ifdef RACE_CTL_BEST_LAP_EN
    lap_timer_d  = lap_timer_q;
    best_lap_d   = best_lap_q;
    lap_time_now = sat_inc16(lap_timer_q);
`endif

    case (state_q)
      ST_IDLE: begin
        lap_d       = 4'd0;
        race_time_d = 16'd0;
`ifdef RACE_CTL_BEST_LAP_EN
        best_lap_d  = TIME_MAX;
`endif
        if (start_rise) begin
          state_d     = ST_COUNTDOWN;
          countdown_d = 2'd3;
          frame_cnt_d = '0;
          cp_armed_d  = 1'b0;
          car_rst_d   = 1'b1;
`ifdef RACE_CTL_BEST_LAP_EN
          lap_timer_d = 16'd0;
          best_lap_d  = TIME_MAX;
`endif
        end
      end

      ST_COUNTDOWN: begin
        if (frame_ended) begin
          if (frame_cnt_q == FC_LAST) begin
            frame_cnt_d = '0;
            countdown_d = countdown_q - 2'd1;
            if (countdown_q == 2'd1) begin
              state_d = ST_RACE;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      ST_RACE: begin
        if (frame_ended) begin
          race_time_d = sat_inc16(race_time_q);
`ifdef RACE_CTL_BEST_LAP_EN
          lap_timer_d = lap_time_now;
`endif
          if (fl_hit && cp_armed_q) begin
            lap_d      = lap_next;
            cp_armed_d = 1'b0;
`ifdef RACE_CTL_BEST_LAP_EN
            lap_timer_d = 16'd0;
            if (lap_time_now < best_lap_q) begin
              best_lap_d = lap_time_now;
            end
`endif
            if (lap_next == LAPS_L) begin
              state_d = ST_FINISH;
            end
          end else if (cp_hit) begin
            cp_armed_d = 1'b1;
          end
        end
      end

      ST_FINISH: begin
        if (start_rise) begin
          state_d     = ST_IDLE;
          lap_d       = 4'd0;
          race_time_d = 16'd0;
`ifdef RACE_CTL_BEST_LAP_EN
          best_lap_d  = TIME_MAX;
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Keys pass only while the next state is RACE, so they drop to zero on
    // the very first cycle the reported state leaves RACE.
    key_out_d  = (state_d == ST_RACE) ? key_in : 4'd0;
    finished_d = (state_d == ST_FINISH);
  end

  // State and output registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      start_btn_q <= 1'b0;
      frame_cnt_q <= '0;
      countdown_q <= 2'd0;
      lap_q       <= 4'd0;
      race_time_q <= 16'd0;
      cp_armed_q  <= 1'b0;
      key_out_q   <= 4'd0;
      car_rst_q   <= 1'b0;
      finished_q  <= 1'b0;
`ifdef RACE_CTL_BEST_LAP_EN
      lap_timer_q <= 16'd0;
      best_lap_q  <= TIME_MAX;
`endif
    end else begin
      state_q     <= state_d;
      start_btn_q <= start_btn_d;
      frame_cnt_q <= frame_cnt_d;
      countdown_q <= countdown_d;
      lap_q       <= lap_d;
      race_time_q <= race_time_d;
      cp_armed_q  <= cp_armed_d;
      key_out_q   <= key_out_d;
      car_rst_q   <= car_rst_d;
      finished_q  <= finished_d;
`ifdef RACE_CTL_BEST_LAP_EN
      lap_timer_q <= lap_timer_d;
      best_lap_q  <= best_lap_d;
`endif
    end
  end

  assign state     = state_q;
  assign countdown = countdown_q;
  assign lap       = lap_q;
  assign race_time = race_time_q;
  assign key_out   = key_out_q;
  assign car_rst   = car_rst_q;
  assign finished  = finished_q;
`ifdef RACE_CTL_BEST_LAP_EN
  assign best_lap  = best_lap_q;
`endif

endmodule

// File: tb/tb_race_ctl.sv
// tb_race_ctl
// Self-checking bench for race_ctl (COUNT_FRAMES=2, LAPS=2). A race-level
// reference model tracks phase, countdown pulses, laps, race time and the
// checkpoint flag from the game rules; every cycle all outputs are compared.
module tb_race_ctl;

  localparam int CF    = 2;
  localparam int NLAPS = 2;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_ended = 1'b0;
  logic        start_btn = 1'b0;
  logic [3:0]  key_in = 4'd0;
  logic [10:0] xpos = 11'd0;
  logic [10:0] ypos = 11'd0;
  logic [3:0]  key_out;
  logic        car_rst;
  logic [1:0]  state;
  logic [1:0]  countdown;
  logic [3:0]  lap;
  logic [15:0] race_time;
  logic        finished;
`ifdef RACE_CTL_BEST_LAP_EN
  logic [15:0] best_lap;
`endif

  race_ctl #(
    .COUNT_FRAMES(CF),
    .LAPS        (NLAPS)
  ) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .frame_ended(frame_ended),
    .start_btn  (start_btn),
    .key_in     (key_in),
    .xpos       (xpos),
    .ypos       (ypos),
    .key_out    (key_out),
    .car_rst    (car_rst),
    .state      (state),
    .countdown  (countdown),
    .lap        (lap),
    .race_time  (race_time),
    .finished   (finished)
`ifdef RACE_CTL_BEST_LAP_EN
    ,
    .best_lap   (best_lap)
`endif
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 countdown, 2 race, 3 finish.
  int       m_phase;
  int       m_pulses;
  int       m_lap;
  int       m_time;
  int       m_best;
  int       m_laptime;
  bit       m_armed;
  bit       m_prev_btn;
  bit       m_carrst;
  logic [3:0] m_key;

  int cpx[4] = '{699, 700, 760, 761};
  int cpy[4] = '{299, 300, 400, 401};
  int flx[4] = '{279, 280, 340, 341};
  int fly[4] = '{199, 200, 300, 301};

  function automatic bit inBox(int x, int y, int x0, int x1, int y0, int y1);
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  task automatic modelReset();
    m_phase = 0; m_pulses = 0; m_lap = 0; m_time = 0;
    m_best = 65535; m_laptime = 0;
    m_armed = 0; m_prev_btn = 0; m_carrst = 0; m_key = 4'd0;
  endtask

  // Applies the game rules for one clock of inputs.
  task automatic modelStep(input bit fe, input bit sb, input logic [3:0] k,
                           input int x, input int y);
    bit rise;
    rise = sb && !m_prev_btn;
    m_prev_btn = sb;
    m_carrst = 0;
    case (m_phase)
      0: if (rise) begin
           m_phase = 1; m_pulses = 0; m_armed = 0; m_carrst = 1;
           m_best = 65535; m_laptime = 0;
         end
      1: if (fe) begin
           m_pulses++;
           if (m_pulses == 3 * CF) m_phase = 2;
         end
      2: if (fe) begin
           if (m_time < 65535) m_time++;
           if (m_laptime < 65535) m_laptime++;
           if (inBox(x, y, 280, 340, 200, 300) && m_armed) begin
             m_lap++;
             m_armed = 0;
             if (m_laptime < m_best) m_best = m_laptime;
             m_laptime = 0;
             if (m_lap == NLAPS) m_phase = 3;
           end else if (inBox(x, y, 700, 760, 300, 400)) begin
             m_armed = 1;
           end
         end
      default: if (rise) begin
           m_phase = 0; m_lap = 0; m_time = 0; m_best = 65535;
         end
    endcase
    m_key = (m_phase == 2) ? k : 4'd0;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("state",     {14'd0, state},     16'(m_phase));
    checkOutput("countdown", {14'd0, countdown},
                (m_phase == 1) ? 16'(3 - m_pulses / CF) : 16'd0);
    checkOutput("lap",       {12'd0, lap},       16'(m_lap));
    checkOutput("race_time", race_time,          16'(m_time));
    checkOutput("key_out",   {12'd0, key_out},   {12'd0, m_key});
    checkOutput("car_rst",   {15'd0, car_rst},   {15'd0, m_carrst});
    checkOutput("finished",  {15'd0, finished},  (m_phase == 3) ? 16'd1 : 16'd0);
`ifdef RACE_CTL_BEST_LAP_EN
    checkOutput("best_lap",  best_lap,           16'(m_best));
`endif
  endtask

  // Drives one cycle of inputs, advances the model and checks after the edge.
  task automatic applyStimulus(input bit fe, input bit sb, input logic [3:0] k,
                               input int x, input int y);
    frame_ended = fe;
    start_btn   = sb;
    key_in      = k;
    xpos        = 11'(x);
    ypos        = 11'(y);
    modelStep(fe, sb, k, x, y);
    @(posedge pclk);
    #2;
    checkAll();
  endtask

  task automatic pickPos(output int x, output int y);
    case ($urandom_range(0, 3))
      0: begin x = cpx[$urandom_range(0, 3)]; y = cpy[$urandom_range(0, 3)]; end
      1: begin x = flx[$urandom_range(0, 3)]; y = fly[$urandom_range(0, 3)]; end
      2: begin x = $urandom_range(0, 1023); y = $urandom_range(0, 767); end
      default: begin x = 500; y = 600; end
    endcase
  endtask

  function automatic logic [3:0] randKey();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd0 : 4'(1 << r);
  endfunction

  // Runs exactly 3*CF countdown pulses; state must be RACE afterwards.
  task automatic directedCountdown();
    for (int i = 0; i < 3 * CF; i++) applyStimulus(1, 0, randKey(), 500, 500);
    checkOutput("race_after_countdown", {14'd0, state}, 16'h2);
  endtask

  // Completes the remaining laps with checkpoint/finish visits.
  task automatic finishLaps();
    for (int i = 0; i < 2 * NLAPS && m_phase == 2; i++) begin
      applyStimulus(1, 0, randKey(), 730, 350);
      applyStimulus(1, 0, randKey(), 300, 250);
    end
    checkOutput("reached_finish", {15'd0, finished}, 16'h1);
  endtask

  task automatic backToIdle();
    applyStimulus(0, 0, 4'd0, 500, 500);
    applyStimulus(0, 1, 4'd0, 500, 500);
    applyStimulus(0, 0, 4'd0, 500, 500);
    checkOutput("back_to_idle", {14'd0, state}, 16'h0);
  endtask

  initial begin
    int x;
    int y;
    modelReset();

    // Reset state before any clock edge is released.
    #12;
    checkAll();
    rst_n = 1'b1;

    $display("[TB] idle: keys and frames must not leak");
    repeat (5) applyStimulus(1'($urandom_range(0, 1)), 0, randKey(), 300, 250);

    $display("[TB] race 1: directed countdown, keys, parking, laps");
    applyStimulus(0, 1, 4'b0001, 300, 250);
    checkOutput("car_rst_pulse", {15'd0, car_rst}, 16'h1);
    applyStimulus(0, 0, 4'b0001, 300, 250);
    checkOutput("car_rst_single", {15'd0, car_rst}, 16'h0);
    for (int i = 0; i < 3 * CF; i++) begin
      checkOutput("cd_digit", {14'd0, countdown}, 16'(3 - i / CF));
      applyStimulus(1, 1'($urandom_range(0, 1)), 4'b0100, 300, 250);
    end
    checkOutput("race_entered", {14'd0, state}, 16'h2);
    applyStimulus(0, 0, 4'b1000, 500, 500);
    checkOutput("key_pass", {12'd0, key_out}, 16'h8);
    repeat (10) begin
      applyStimulus(1, 0, 4'd0, 300, 250);
      applyStimulus(0, 0, 4'd0, 300, 250);
    end
    checkOutput("park_no_lap", {12'd0, lap}, 16'h0);
    applyStimulus(1, 0, 4'd0, 730, 350);
    applyStimulus(1, 0, 4'd0, 300, 250);
    checkOutput("first_lap", {12'd0, lap}, 16'h1);
    applyStimulus(1, 0, 4'b0100, 760, 400);
    applyStimulus(1, 0, 4'b0100, 340, 300);
    checkOutput("finish_state", {14'd0, state}, 16'h3);
    checkOutput("finish_key_zero", {12'd0, key_out}, 16'h0);
    checkOutput("finish_time", race_time, 16'd14);
    repeat (5) applyStimulus(1, 0, randKey(), 730, 350);
    repeat (5) applyStimulus(1, 0, randKey(), 300, 250);
    checkOutput("time_frozen", race_time, 16'd14);
    applyStimulus(0, 1, 4'd0, 500, 500);
    checkOutput("finish_to_idle_lap", {12'd0, lap}, 16'h0);
    checkOutput("finish_to_idle_time", race_time, 16'h0);
    repeat (3) applyStimulus(1, 1, 4'd0, 500, 500);
    checkOutput("held_btn_stays_idle", {14'd0, state}, 16'h0);
    applyStimulus(0, 0, 4'd0, 500, 500);

    $display("[TB] race 2: laps of 120 and 90 frames");
    applyStimulus(0, 1, 4'd0, 500, 500);
    directedCountdown();
    for (int f = 1; f <= 120; f++) begin
      x = (f == 60) ? 700 : (f == 120) ? 280 : 500;
      y = (f == 60) ? 300 : (f == 120) ? 200 : 500;
      applyStimulus(1, 0, randKey(), x, y);
    end
    for (int f = 1; f <= 90; f++) begin
      x = (f == 45) ? 760 : (f == 90) ? 340 : 500;
      y = (f == 45) ? 400 : (f == 90) ? 300 : 500;
      applyStimulus(1, 0, randKey(), x, y);
    end
    checkOutput("race2_laps", {12'd0, lap}, 16'h2);
    checkOutput("race2_time", race_time, 16'd210);
`ifdef RACE_CTL_BEST_LAP_EN
    checkOutput("race2_best_lap", best_lap, 16'd90);
`endif
    backToIdle();

    $display("[TB] race 3: randomized positions, frames and buttons");
    applyStimulus(0, 1, randKey(), 500, 500);
    for (int i = 0; i < 200 && m_phase == 1; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), randKey(), 300, 250);
    checkOutput("race3_countdown_done", {14'd0, state}, 16'h2);
    for (int i = 0; i < 3000 && m_phase == 2; i++) begin
      pickPos(x, y);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), randKey(), x, y);
    end
    if (m_phase == 2) finishLaps();
    backToIdle();

    $display("[TB] race 4: race_time saturation");
    applyStimulus(0, 1, 4'd0, 500, 500);
    directedCountdown();
    repeat (70000) applyStimulus(1, 0, 4'd0, 500, 600);
    checkOutput("time_saturated", race_time, 16'hFFFF);
    finishLaps();
    checkOutput("saturated_frozen", race_time, 16'hFFFF);
    backToIdle();

    $display("[TB] race 5: asynchronous reset mid-countdown");
    applyStimulus(0, 1, 4'd0, 500, 500);
    repeat (3) applyStimulus(1, 0, 4'd0, 500, 500);
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkOutput("async_reset_state", {14'd0, state}, 16'h0);
    frame_ended = 1'b0;
    start_btn   = 1'b0;
    key_in      = 4'd0;
    #2;
    rst_n = 1'b1;
    applyStimulus(1, 0, 4'd0, 500, 500);
    checkOutput("no_car_rst_from_reset", {15'd0, car_rst}, 16'h0);
    applyStimulus(0, 1, 4'd0, 500, 500);
    checkOutput("restart_countdown", {14'd0, countdown}, 16'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
